// File: rtl/client_vip_pin_verify.sv
// VIP PIN gate for client menus: reads a PIN via the array-input block under a
// per-second countdown, counts failed tries, enforces a lockout and writes the new VIP status.
module client_vip_pin_verify #(
  parameter int PERIOD    = 100_000_000,
  parameter int DIGITS    = 4,
  parameter int TIMEOUT_S = 9,
  parameter int MAX_TRY   = 3,
  parameter int LOCK_S    = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          press,
  input  logic                mode_i,
  input  logic [1:0]          vip_i,
  input  logic [5*DIGITS-1:0] pwd_i,
  input  logic                arr_over_i,
  input  logic [5*DIGITS-1:0] arr_data_i,
  output logic                arr_en_o,
  output logic [3:0]          arr_cnt_o,
  output logic                wr_o,
  output logic [1:0]          vip_o,
  output logic                done_o,
  output logic                locked_o,
  output logic [29:0]         show_o
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  localparam logic [2:0] P_RLS = 3'b001;
  localparam logic [2:0] P_CON = 3'b010;
  localparam logic [2:0] P_RIS = 3'b100;

  localparam logic [4:0] G_BLANK = 5'd31;
  localparam logic [4:0] G_G     = 5'd30;
  localparam logic [4:0] G_O     = 5'd21;
  localparam logic [4:0] G_D     = 5'd13;
  localparam logic [4:0] G_E     = 5'd14;
  localparam logic [4:0] G_R     = 5'd24;
  localparam logic [4:0] G_L     = 5'd19;
  localparam logic [4:0] G_C     = 5'd12;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_OK, S_FAIL, S_NOELIG, S_LOCK, S_HALT
  } state_t;

  state_t        state, state_nxt, view;
  logic [3:0]    secs;
  logic [PW-1:0] entry_pre, lock_pre;
  logic [3:0]    attempts, attempts_nxt;
  logic [6:0]    lock_rem;
  logic          wr_r, wr_nxt, done_r, done_nxt;
  logic [1:0]    vip_r, required;
  logic          load_secs, load_lock, fail_try;
  logic          entry_tick, lock_tick;
  logic [4:0]    tries_left, lock_tens, lock_ones;

  assign required   = mode_i ? 2'b11 : 2'b10;
  assign entry_tick = en && (state == S_ENTRY) && (entry_pre == PRE_LAST);
  assign lock_tick  = (lock_rem != 7'd0) && (lock_pre == PRE_LAST);

  always_comb begin
    state_nxt    = state;
    attempts_nxt = attempts;
    wr_nxt       = 1'b0;
    done_nxt     = 1'b0;
    load_secs    = 1'b0;
    load_lock    = 1'b0;
    fail_try     = 1'b0;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (lock_rem != 7'd0) begin
            state_nxt = S_LOCK;
          end else if (vip_i == required) begin
            state_nxt = S_ENTRY;
            load_secs = 1'b1;
          end else begin
            state_nxt = S_NOELIG;
          end
        end
        S_ENTRY: begin
          // A completed entry takes priority over the countdown expiring.
          if (arr_over_i) begin
            if (arr_data_i == pwd_i) begin
              state_nxt    = S_OK;
              wr_nxt       = 1'b1;
              attempts_nxt = 4'd0;
            end else begin
              fail_try = 1'b1;
            end
          end else if (secs == 4'd0) begin
            fail_try = 1'b1;
          end else if (press == P_RLS) begin
            state_nxt = S_HALT;
            done_nxt  = 1'b1;
          end else if (press == P_RIS) begin
            state_nxt = S_IDLE;
          end
          if (fail_try) begin
            if (attempts + 4'd1 >= 4'(MAX_TRY)) begin
              attempts_nxt = 4'd0;
              load_lock    = 1'b1;
              state_nxt    = S_LOCK;
            end else begin
              attempts_nxt = attempts + 4'd1;
              state_nxt    = S_FAIL;
            end
          end
        end
        S_OK, S_FAIL, S_NOELIG: begin
          if (press == P_CON || press == P_RLS) begin
            state_nxt = S_HALT;
            done_nxt  = 1'b1;
          end else if (press == P_RIS) begin
            state_nxt = S_IDLE;
          end
        end
        S_LOCK: begin
          if (press == P_RLS) begin
            state_nxt = S_HALT;
            done_nxt  = 1'b1;
          end else if (lock_rem == 7'd0 || (lock_rem == 7'd1 && lock_tick)) begin
            state_nxt = S_IDLE;
          end
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      attempts <= 4'd0;
      wr_r     <= 1'b0;
      done_r   <= 1'b0;
      vip_r    <= 2'b00;
    end else begin
      state    <= state_nxt;
      attempts <= attempts_nxt;
      wr_r     <= wr_nxt;
      done_r   <= done_nxt;
      vip_r    <= wr_nxt ? (mode_i ? 2'b10 : 2'b11) : 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      secs      <= 4'd0;
      entry_pre <= '0;
    end else if (load_secs) begin
      secs      <= 4'(TIMEOUT_S);
      entry_pre <= '0;
    end else if (!en || state != S_ENTRY) begin
      secs      <= 4'd0;
      entry_pre <= '0;
    end else if (entry_tick) begin
      entry_pre <= '0;
      if (secs != 4'd0) secs <= secs - 4'd1;
    end else begin
      entry_pre <= entry_pre + PRE_ONE;
    end
  end

  // The lockout keeps counting down regardless of en; only rst cancels it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_rem <= 7'd0;
      lock_pre <= '0;
    end else if (load_lock) begin
      lock_rem <= 7'(LOCK_S);
      lock_pre <= '0;
    end else if (lock_rem == 7'd0) begin
      lock_pre <= '0;
    end else if (lock_tick) begin
      lock_pre <= '0;
      lock_rem <= lock_rem - 7'd1;
    end else begin
      lock_pre <= lock_pre + PRE_ONE;
    end
  end

  assign view       = en ? state : S_IDLE;
  assign tries_left = 5'(MAX_TRY) - {1'b0, attempts};
  assign lock_tens  = 5'(lock_rem / 7'd10);
  assign lock_ones  = 5'(lock_rem % 7'd10);

  assign arr_en_o  = (view == S_ENTRY);
  assign arr_cnt_o = arr_en_o ? 4'(DIGITS) : 4'd0;
  assign wr_o      = wr_r & en;
  assign vip_o     = en ? vip_r : 2'b00;
  assign done_o    = done_r & en;
  assign locked_o  = (lock_rem != 7'd0);

  always_comb begin
    show_o = {6{G_BLANK}};
    case (view)
      S_ENTRY:  show_o = {1'b0, secs, {5{G_BLANK}}};
      S_OK:     show_o = {G_BLANK, G_BLANK, G_G, G_O, G_O, G_D};
      S_FAIL:   show_o = {G_E, G_R, G_R, G_O, G_R, tries_left};
      S_NOELIG: show_o = {G_BLANK, G_E, G_R, G_R, G_O, G_R};
      S_LOCK:   show_o = {G_L, G_O, G_C, G_BLANK, lock_tens, lock_ones};
      default:  show_o = {6{G_BLANK}};
    endcase
  end

endmodule

// File: tb/tb_client_vip_pin_verify.sv
// Bench for client_vip_pin_verify: vector table for single transactions plus
// hand-written lockout, timeout and reset sequences; VIP writes are checked via a scoreboard queue.
module tb_client_vip_pin_verify;

  localparam int PERIOD = 10, DIGITS = 4, TIMEOUT_S = 3, MAX_TRY = 2, LOCK_S = 12;

  localparam logic [2:0] B_NONE = 3'b111;
  localparam logic [2:0] B_RLS  = 3'b001;
  localparam logic [2:0] B_CON  = 3'b010;
  localparam logic [2:0] B_RIS  = 3'b100;

  localparam logic [4:0] GB = 5'd31, GG = 5'd30, GO = 5'd21, GD = 5'd13;
  localparam logic [4:0] GE = 5'd14, GR = 5'd24, GL = 5'd19, GC = 5'd12;

  localparam logic [29:0] SH_BLANK = {6{GB}};
  localparam logic [29:0] SH_GOOD  = {GB, GB, GG, GO, GO, GD};
  localparam logic [29:0] SH_ERR   = {GB, GE, GR, GR, GO, GR};
  localparam logic [29:0] SH_FAIL1 = {GE, GR, GR, GO, GR, 5'd1};

  logic        clk, rst, en, mode_i, arr_over_i;
  logic [2:0]  press;
  logic [1:0]  vip_i;
  logic [19:0] pwd_i, arr_data_i;
  logic        arr_en_o, wr_o, done_o, locked_o;
  logic [3:0]  arr_cnt_o;
  logic [1:0]  vip_o;
  logic [29:0] show_o;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic        mode;
    logic [1:0]  vip;
    logic [19:0] pwd;
    logic [19:0] data;
    logic [29:0] exp_show;
    logic        exp_wr;
    logic [1:0]  exp_vip;
  } vec_t;

  vec_t vecs[8];

  client_vip_pin_verify #(
    .PERIOD(PERIOD), .DIGITS(DIGITS), .TIMEOUT_S(TIMEOUT_S),
    .MAX_TRY(MAX_TRY), .LOCK_S(LOCK_S)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .press(press), .mode_i(mode_i),
    .vip_i(vip_i), .pwd_i(pwd_i), .arr_over_i(arr_over_i), .arr_data_i(arr_data_i),
    .arr_en_o(arr_en_o), .arr_cnt_o(arr_cnt_o), .wr_o(wr_o), .vip_o(vip_o),
    .done_o(done_o), .locked_o(locked_o), .show_o(show_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] entry_show(input int s);
    return {5'(s), {5{GB}}};
  endfunction

  function automatic logic [29:0] lock_show(input int r);
    return {GL, GO, GC, GB, 5'(r / 10), 5'(r % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pressBtn(input logic [2:0] b);
    press = b;
    step();
    press = B_NONE;
  endtask

  task automatic enterPin(input logic [19:0] d, input logic ok, input logic [1:0] v);
    arr_data_i = d;
    arr_over_i = 1'b1;
    if (ok) exp_q.push_back(v);
    step();
    arr_over_i = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1; en = 1'b0; press = B_NONE; arr_over_i = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Every VIP write must match the oldest pending expectation and never coincide with done_o.
  always @(negedge clk) begin
    if (!rst && wr_o) begin
      checkOutput("wr_with_done", 32'(done_o), 32'd0);
      checkOutput("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) checkOutput("vip_o", 32'(vip_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic applyStimulus(input vec_t v, input int i);
    logic elig;
    elig = (v.vip == (v.mode ? 2'b11 : 2'b10));
    en = 1'b0;
    step();
    mode_i = v.mode; vip_i = v.vip; pwd_i = v.pwd;
    en = 1'b1;
    step();
    checkOutput($sformatf("v%0d_arr_en", i), 32'(arr_en_o), 32'(elig));
    if (elig) begin
      checkOutput($sformatf("v%0d_arr_cnt", i), 32'(arr_cnt_o), 32'(DIGITS));
      checkOutput($sformatf("v%0d_entry_show", i), 32'(show_o), 32'(entry_show(TIMEOUT_S)));
      enterPin(v.data, v.exp_wr, v.exp_vip);
      checkOutput($sformatf("v%0d_arr_en_drop", i), 32'(arr_en_o), 32'd0);
    end
    checkOutput($sformatf("v%0d_show", i), 32'(show_o), 32'(v.exp_show));
    pressBtn(B_CON);
    checkOutput($sformatf("v%0d_done", i), 32'(done_o), 32'd1);
    checkOutput($sformatf("v%0d_halt_show", i), 32'(show_o), 32'(SH_BLANK));
    step();
    checkOutput($sformatf("v%0d_done_clr", i), 32'(done_o), 32'd0);
    en = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; press = B_NONE; mode_i = 1'b0; vip_i = 2'b00;
    pwd_i = '0; arr_data_i = '0; arr_over_i = 1'b0;

    vecs[0] = '{1'b0, 2'b10, 20'h01234, 20'h01234, SH_GOOD,  1'b1, 2'b11};
    vecs[1] = '{1'b1, 2'b10, 20'h01234, 20'h01234, SH_ERR,   1'b0, 2'b00};
    vecs[2] = '{1'b1, 2'b11, 20'h0abcd, 20'h0abcd, SH_GOOD,  1'b1, 2'b10};
    vecs[3] = '{1'b0, 2'b10, 20'h11111, 20'h11110, SH_FAIL1, 1'b0, 2'b00};
    vecs[4] = '{1'b0, 2'b11, 20'h11111, 20'h11111, SH_ERR,   1'b0, 2'b00};
    vecs[5] = '{1'b0, 2'b10, 20'h54321, 20'h54321, SH_GOOD,  1'b1, 2'b11};
    vecs[6] = '{1'b1, 2'b11, 20'h7f0e1, 20'h7f0e0, SH_FAIL1, 1'b0, 2'b00};
    vecs[7] = '{1'b1, 2'b11, 20'h7f0e1, 20'h7f0e1, SH_GOOD,  1'b1, 2'b10};

    doReset();
    checkOutput("rst_show", 32'(show_o), 32'(SH_BLANK));
    checkOutput("rst_arr_en", 32'(arr_en_o), 32'd0);
    checkOutput("rst_arr_cnt", 32'(arr_cnt_o), 32'd0);
    checkOutput("rst_wr", 32'(wr_o), 32'd0);
    checkOutput("rst_vip", 32'(vip_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_locked", 32'(locked_o), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Two wrong PINs lock the user out; lockout keeps running with en low.
    $display("[TB] lockout sequence");
    doReset();
    mode_i = 1'b0; vip_i = 2'b10; pwd_i = 20'h01234;
    en = 1'b1;
    step();
    enterPin(20'h01235, 1'b0, 2'b00);
    checkOutput("lk_fail_show", 32'(show_o), 32'(SH_FAIL1));
    pressBtn(B_RIS);
    step();
    checkOutput("lk_reentry", 32'(arr_en_o), 32'd1);
    enterPin(20'h01230, 1'b0, 2'b00);
    checkOutput("lk_locked", 32'(locked_o), 32'd1);
    checkOutput("lk_show12", 32'(show_o), 32'(lock_show(12)));
    en = 1'b0;
    #1;
    checkOutput("lk_en0_show", 32'(show_o), 32'(SH_BLANK));
    repeat (50) step();
    checkOutput("lk_en0_locked", 32'(locked_o), 32'd1);
    en = 1'b1;
    step();
    checkOutput("lk_show7", 32'(show_o), 32'(lock_show(7)));
    n = 0;
    while (!arr_en_o && n < 200) begin
      step();
      n++;
    end
    checkOutput("lk_expire_cycles", 32'(n), 32'd70);
    checkOutput("lk_unlocked", 32'(locked_o), 32'd0);

    // Countdown expiry counts as a failure; a PIN arriving as secs reaches 0 still wins.
    $display("[TB] timeout sequence");
    repeat (10) step();
    checkOutput("to_secs2", 32'(show_o), 32'(entry_show(2)));
    repeat (19) step();
    checkOutput("to_secs1", 32'(show_o), 32'(entry_show(1)));
    step();
    checkOutput("to_secs0", 32'(show_o), 32'(entry_show(0)));
    step();
    checkOutput("to_fail_show", 32'(show_o), 32'(SH_FAIL1));
    pressBtn(B_RIS);
    step();
    repeat (30) step();
    checkOutput("to_race_secs0", 32'(show_o), 32'(entry_show(0)));
    enterPin(20'h01234, 1'b1, 2'b11);
    checkOutput("to_race_good", 32'(show_o), 32'(SH_GOOD));
    pressBtn(B_CON);
    checkOutput("to_race_done", 32'(done_o), 32'd1);
    en = 1'b0; step(); en = 1'b1; step();
    enterPin(20'h00000, 1'b0, 2'b00);
    checkOutput("to_attempts_cleared", 32'(show_o), 32'(SH_FAIL1));
    pressBtn(B_RLS);
    checkOutput("to_rls_done", 32'(done_o), 32'd1);

    // Reset in the middle of a lockout clears it immediately.
    $display("[TB] reset during lock sequence");
    doReset();
    en = 1'b1;
    step();
    enterPin(20'h00001, 1'b0, 2'b00);
    pressBtn(B_RIS);
    step();
    enterPin(20'h00002, 1'b0, 2'b00);
    checkOutput("rl_locked", 32'(locked_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rl_locked_clr", 32'(locked_o), 32'd0);
    checkOutput("rl_show", 32'(show_o), 32'(SH_BLANK));
    en = 1'b0;
    step();
    rst = 1'b0;
    step();
    en = 1'b1;
    step();
    checkOutput("rl_entry", 32'(show_o), 32'(entry_show(TIMEOUT_S)));
    pressBtn(B_RLS);
    checkOutput("rl_entry_rls_done", 32'(done_o), 32'd1);
    checkOutput("rl_entry_rls_arr", 32'(arr_en_o), 32'd0);
    en = 1'b0; step(); en = 1'b1; step();
    enterPin(20'h00003, 1'b0, 2'b00);
    checkOutput("rl_attempts0", 32'(show_o), 32'(SH_FAIL1));

    en = 1'b0;
    step(); step();
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
